// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, a programmable
// wait-state count, then byte/half/word access to an internal word RAM with an
// error response for misaligned, out-of-range or illegal-size requests.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LatLast = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            do_access;
    logic            access_err;
    logic [IdxW-1:0] idx;
    logic [31:0]     rword;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;
    logic [3:0]      wmask;
    logic [31:0]     wword;

    assign accept     = req_valid && (state_q == StIdle);
    assign idx        = addr_q[IdxW+1:2];
    assign rword      = mem[idx];
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Classify the latched request: illegal size, misalignment or beyond the RAM.
    always_comb begin
        access_err = 1'b0;
        if (size_q == 2'b11) access_err = 1'b1;
        if (size_q == 2'b01 && addr_q[0]) access_err = 1'b1;
        if (size_q == 2'b10 && addr_q[1:0] != 2'b00) access_err = 1'b1;
        if (addr_q[31:2] >= 30'(DEPTH_WORDS)) access_err = 1'b1;
    end

    // Select the addressed lane(s) of the read word and extend to 32 bits.
    always_comb begin
        byte_sel = rword[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel  = addr_q[1] ? rword[31:16] : rword[15:0];
        load_data = rword;
        case (size_q)
            2'b00: load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01: load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = rword;
        endcase
    end

    // Byte-lane enables and replicated store data so each lane sees its slice.
    always_comb begin
        wmask = 4'b1111;
        wword = wdata_q;
        case (size_q)
            2'b00: begin
                wmask = 4'b0001 << addr_q[1:0];
                wword = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask = addr_q[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_q[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wword = wdata_q;
            end
        endcase
    end

    // FSM next state, handshake outputs and response data. WAIT always lasts
    // LATENCY+1 cycles, so the response appears LATENCY+1 edges after acceptance.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        do_access  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = StWait;
                    cnt_d   = 4'd0;
                end
            end
            StWait: begin
                if (cnt_q == LatLast) begin
                    do_access = 1'b1;
                    state_d   = StResp;
                    err_d     = access_err;
                    rdata_d   = (access_err || we_q) ? 32'b0 : load_data;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    // Return outputs to their idle values once consumed.
                    state_d = StIdle;
                    rdata_d = 32'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Capture the request on acceptance; held for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'b0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

    // RAM write port: only a good store at the access step touches the array.
    always_ff @(posedge clk) begin
        if (do_access && we_q && !access_err) begin
            for (int l = 0; l < 4; l++) begin
                if (wmask[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
            end
        end
    end

endmodule
